clic_ip_gateway: RTL and testbench
==================================

CLIC_IP_GATEWAY -- requirements
Module: clic_ip_gateway

Interface
REQ-001 Parameter N_SOURCE, default 32: number of interrupt sources (1..1024).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on raw sources (legal 1..3).
REQ-003 Parameter IdWidth, default $clog2(N_SOURCE) with a minimum of 1: width of the claim id.
REQ-004 clk_i  input  1  single clock for all state.
REQ-005 rst_ni  input  1  reset, asynchronous and active-low.
REQ-006 intr_src_i  input  N_SOURCE  raw asynchronous interrupt lines, active-high.
REQ-007 le_i  input  N_SOURCE  trigger select per source: 1 = positive edge, 0 = positive level (driven from the attr_trig[0] field).
REQ-008 sw_set_i  input  N_SOURCE  one-cycle pulse per source: software write of 1 to the pending bit.
REQ-009 sw_clr_i  input  N_SOURCE  one-cycle pulse per source: software write of 0 to the pending bit.
REQ-010 claim_valid_i  input  1  core took an interrupt this cycle.
REQ-011 claim_id_i  input  IdWidth  id of the taken interrupt; qualified by claim_valid_i.
REQ-012 ip_o  output  N_SOURCE  pending vector; feeds the register-file ip hardware write (written every cycle).
REQ-013 missed_o  output  N_SOURCE  sticky flag: an edge arrived while the source was already pending.

Function
REQ-014 Each intr_src_i bit SHALL pass through SYNC_STAGES flops; the last stage is "sync[i]".
REQ-015 A flop "prev[i]" SHALL hold sync[i] delayed by one cycle; rise[i] = sync[i] & ~prev[i].
REQ-016 Level mode (le_i[i]=0): ip_o[i] SHALL equal sync[i] combinationally; pend[i] SHALL be forced to 0 on the next clock; missed_o[i] SHALL hold its value.
REQ-017 Level mode: sw_set_i, sw_clr_i and claims for that source SHALL have no effect.
REQ-018 Edge mode (le_i[i]=1): ip_o[i] SHALL equal the registered bit pend[i].
REQ-019 Edge mode set term: set[i] = rise[i] | sw_set_i[i].
REQ-020 Edge mode clear term: clr[i] = sw_clr_i[i] | (claim_valid_i & claim_id_i == i).
REQ-021 Edge mode next state: pend[i] <= set[i] ? 1 : (clr[i] ? 0 : pend[i]); set SHALL win over a simultaneous clear, so no edge is lost.
REQ-022 missed_o[i] SHALL be set when le_i[i]=1, rise[i]=1 and pend[i]=1 while no clear is present in that cycle.
REQ-023 missed_o[i] SHALL be cleared by sw_clr_i[i]; a simultaneous set condition SHALL win.
REQ-024 A claim_id_i value >= N_SOURCE SHALL be ignored.
REQ-025 Latency from an intr_src_i rising edge to ip_o: SYNC_STAGES cycles in level mode; SYNC_STAGES+1 cycles in edge mode.
REQ-026 A source held high continuously SHALL produce exactly one edge; re-pending requires a low of at least one synchronized cycle.
REQ-027 A level-to-edge switch with the source already high SHALL NOT create a pending bit; prev keeps tracking in both modes.
REQ-028 An edge-to-level switch SHALL drop any edge pending; ip_o follows sync from that cycle.
REQ-029 All sources SHALL be processed in parallel and independently; there is no arbitration inside the block.

Reset
REQ-030 While rst_ni=0, all synchronizer stages, prev, pend and missed SHALL be 0, asynchronously.
REQ-031 ip_o SHALL be 0 and missed_o SHALL be 0 during and immediately after reset.
REQ-032 A source that is high when reset is released SHALL be seen as level-high after SYNC_STAGES cycles.
REQ-033 Such a source SHALL produce one rising edge in edge mode, because prev resets to 0.
REQ-034 Reset asserted mid-operation SHALL discard every pending and missed bit; no state survives.

Verification
REQ-035 SYNC_STAGES=2, source 3 in edge mode: pulse intr_src_i[3] high for 1 cycle at cycle 10 -> ip_o[3]=1 from cycle 13; claim id 3 at cycle 20 -> ip_o[3]=0 at cycle 21.
REQ-036 Source 5 in level mode: drive high at cycle 10 -> ip_o[5]=1 from cycle 12; drive low at cycle 30 -> ip_o[5]=0 at cycle 32; sw_clr_i[5] while high -> no change.
REQ-037 Edge mode, new rise[7] coincides with claim id 7 -> ip_o[7] stays 1 and missed_o[7] stays 0.
REQ-038 Edge mode, second edge on source 1 while pending with no clear -> missed_o[1]=1; sw_clr_i[1] -> ip_o[1]=0 and missed_o[1]=0 next cycle.
REQ-039 N_SOURCE=5, claim_id_i=7 with claim_valid_i=1 -> no ip_o change; sw_set_i[0] -> ip_o[0]=1 next cycle.
REQ-040 Assert rst_ni=0 mid-cycle with pending bits set -> ip_o=0 immediately; source held high across reset release in edge mode -> a single pend at cycle SYNC_STAGES+1 after release.

Source files
------------

// File: rtl/clic_ip_gateway.sv
// clic_ip_gateway: per-source interrupt pending gateway with synchronizer, edge/level trigger, claim clear and missed-edge flag
module clic_ip_gateway #(
   parameter int N_SOURCE    = 32,
   parameter int SYNC_STAGES = 2,
   parameter int IdWidth     = (N_SOURCE > 1) ? $clog2(N_SOURCE) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] intr_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] sw_set_i,
   input  logic [N_SOURCE-1:0] sw_clr_i,
   input  logic                claim_valid_i,
   input  logic [IdWidth-1:0]  claim_id_i,
   output logic [N_SOURCE-1:0] ip_o,
   output logic [N_SOURCE-1:0] missed_o
);
   logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];
   logic [N_SOURCE-1:0] sync, prev, rise, pend, claim_hit, set, clr;

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~prev;

   // raw lines pass through the synchronizer chain; prev tracks sync in both modes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         prev <= '0;
      end else begin
         sync_q[0] <= intr_src_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         prev <= sync;
      end
   end

   // one-hot claim decode; ids beyond the last source match nothing
   always_comb begin
      claim_hit = '0;
      for (int i = 0; i < N_SOURCE; i++) claim_hit[i] = claim_valid_i && (claim_id_i == IdWidth'(i));
   end

   assign set  = rise | sw_set_i;
   assign clr  = sw_clr_i | claim_hit;
   assign ip_o = (le_i & pend) | (~le_i & sync);

   // edge-mode pending with set priority; level mode flushes pend and freezes missed
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend     <= '0;
         missed_o <= '0;
      end else begin
         pend     <= le_i & (set | (pend & ~clr));
         missed_o <= (le_i & rise & pend & ~clr) | (missed_o & ~(le_i & sw_clr_i));
      end
   end
endmodule

// File: tb/tb_clic_ip_gateway.sv
// tb_clic_ip_gateway: directed checks of the interrupt pending gateway
module tb_clic_ip_gateway;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] src, le, sset, sclr, ip, missed;
   logic        cv;
   logic [4:0]  cid;
   logic [4:0]  f_src, f_le, f_sset, f_sclr, f_ip, f_missed;
   logic        f_cv;
   logic [2:0]  f_cid;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   clic_ip_gateway dut (
      .clk_i(clk), .rst_ni(rst_n), .intr_src_i(src), .le_i(le), .sw_set_i(sset), .sw_clr_i(sclr),
      .claim_valid_i(cv), .claim_id_i(cid), .ip_o(ip), .missed_o(missed)
   );

   clic_ip_gateway #(.N_SOURCE(5)) dut5 (
      .clk_i(clk), .rst_ni(rst_n), .intr_src_i(f_src), .le_i(f_le), .sw_set_i(f_sset), .sw_clr_i(f_sclr),
      .claim_valid_i(f_cv), .claim_id_i(f_cid), .ip_o(f_ip), .missed_o(f_missed)
   );

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; src = '0; le = 32'h8A; sset = '0; sclr = '0; cv = 1'b0; cid = '0;
      f_src = '0; f_le = 5'h1F; f_sset = '0; f_sclr = '0; f_cv = 1'b0; f_cid = '0;
      tick(2);
      chk("reset_ip", ip, 32'h0);
      chk("reset_missed", missed, 32'h0);
      chk("reset_f_ip", {27'h0, f_ip}, 32'h0);
      rst_n = 1'b1;
      tick(3);
      chk("post_reset_ip", ip, 32'h0);
      chk("post_reset_missed", missed, 32'h0);
      // five-source instance: sw set, out-of-range claim, real claim
      f_sset = 5'h01; tick; f_sset = '0;
      chk("n5_sw_set", {27'h0, f_ip}, 32'h1);
      f_cv = 1'b1; f_cid = 3'd7; tick; f_cv = 1'b0;
      chk("n5_claim_oob", {27'h0, f_ip}, 32'h1);
      f_cv = 1'b1; f_cid = 3'd0; tick; f_cv = 1'b0;
      chk("n5_claim0", {27'h0, f_ip}, 32'h0);
      // edge source 3: one-cycle pulse, latency 3, claim clears
      src[3] = 1'b1; tick; src[3] = 1'b0;
      chk("e3_lat1", {31'h0, ip[3]}, 32'h0);
      tick;
      chk("e3_lat2", {31'h0, ip[3]}, 32'h0);
      tick;
      chk("e3_lat3", {31'h0, ip[3]}, 32'h1);
      tick(5);
      chk("e3_hold", {31'h0, ip[3]}, 32'h1);
      cv = 1'b1; cid = 5'd3; tick; cv = 1'b0;
      chk("e3_claim", {31'h0, ip[3]}, 32'h0);
      chk("e3_missed", {31'h0, missed[3]}, 32'h0);
      // level source 5: latency 2, sw_clr and claim ignored, falls after 2
      src[5] = 1'b1; tick;
      chk("l5_lat1", {31'h0, ip[5]}, 32'h0);
      tick;
      chk("l5_lat2", {31'h0, ip[5]}, 32'h1);
      sclr[5] = 1'b1; tick; sclr[5] = 1'b0;
      chk("l5_swclr", {31'h0, ip[5]}, 32'h1);
      cv = 1'b1; cid = 5'd5; tick; cv = 1'b0;
      chk("l5_claim", {31'h0, ip[5]}, 32'h1);
      src[5] = 1'b0; tick;
      chk("l5_fall1", {31'h0, ip[5]}, 32'h1);
      tick;
      chk("l5_fall2", {31'h0, ip[5]}, 32'h0);
      sset[5] = 1'b1; tick; sset[5] = 1'b0;
      chk("l5_swset", {31'h0, ip[5]}, 32'h0);
      tick;
      chk("l5_swset2", {31'h0, ip[5]}, 32'h0);
      // edge source 7: new rise coincides with claim
      src[7] = 1'b1; tick; src[7] = 1'b0; tick(2);
      chk("e7_pend", {31'h0, ip[7]}, 32'h1);
      src[7] = 1'b1; tick; src[7] = 1'b0; tick;
      cv = 1'b1; cid = 5'd7; tick; cv = 1'b0;
      chk("e7_set_wins", {31'h0, ip[7]}, 32'h1);
      chk("e7_no_missed", {31'h0, missed[7]}, 32'h0);
      sclr[7] = 1'b1; tick; sclr[7] = 1'b0;
      chk("e7_swclr", {31'h0, ip[7]}, 32'h0);
      // edge source 1: second edge while pending sets missed
      src[1] = 1'b1; tick; src[1] = 1'b0; tick(2);
      chk("e1_pend", {31'h0, ip[1]}, 32'h1);
      src[1] = 1'b1; tick; src[1] = 1'b0; tick;
      chk("e1_missed_pre", {31'h0, missed[1]}, 32'h0);
      tick;
      chk("e1_missed", {31'h0, missed[1]}, 32'h1);
      tick(2);
      chk("e1_missed_sticky", {31'h0, missed[1]}, 32'h1);
      sclr[1] = 1'b1; tick; sclr[1] = 1'b0;
      chk("e1_clr_ip", {31'h0, ip[1]}, 32'h0);
      chk("e1_clr_missed", {31'h0, missed[1]}, 32'h0);
      // continuous high on edge source 3 gives one edge only
      src[3] = 1'b1; tick(3);
      chk("e3_cont_pend", {31'h0, ip[3]}, 32'h1);
      cv = 1'b1; cid = 5'd3; tick; cv = 1'b0;
      chk("e3_cont_claim", {31'h0, ip[3]}, 32'h0);
      tick(4);
      chk("e3_cont_once", {31'h0, ip[3]}, 32'h0);
      chk("e3_cont_missed", {31'h0, missed[3]}, 32'h0);
      src[3] = 1'b0; tick(3);
      // level-to-edge switch while high creates nothing
      src[5] = 1'b1; tick(3);
      le[5] = 1'b1; tick(3);
      chk("l2e_no_pend", {31'h0, ip[5]}, 32'h0);
      src[5] = 1'b0; tick(3); le[5] = 1'b0;
      // edge-to-level switch drops pending
      sset[7] = 1'b1; tick; sset[7] = 1'b0;
      chk("e7_swset", {31'h0, ip[7]}, 32'h1);
      le[7] = 1'b0; #1;
      chk("e2l_follow", {31'h0, ip[7]}, 32'h0);
      tick; le[7] = 1'b1; #1;
      chk("e2l_dropped", {31'h0, ip[7]}, 32'h0);
      // pending + missed on source 1, then mid-cycle reset
      sset[1] = 1'b1; tick; sset[1] = 1'b0;
      src[1] = 1'b1; tick; src[1] = 1'b0; tick(2);
      chk("pre_rst_ip", ip, 32'h2);
      chk("pre_rst_missed", missed, 32'h2);
      #3 rst_n = 1'b0; #1;
      chk("mid_rst_ip", ip, 32'h0);
      chk("mid_rst_missed", missed, 32'h0);
      src[3] = 1'b1; src[5] = 1'b1;
      tick;
      chk("in_rst_ip", ip, 32'h0);
      rst_n = 1'b1;
      tick;
      chk("rel1_ip", ip, 32'h0);
      tick;
      chk("rel2_ip", ip, 32'h20);
      tick;
      chk("rel3_ip", ip, 32'h28);
      cv = 1'b1; cid = 5'd3; tick; cv = 1'b0;
      chk("rel_claim", ip, 32'h20);
      tick(3);
      chk("rel_single", ip, 32'h20);
      chk("rel_missed", missed, 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
